// File: rtl/div_seq_pkg.sv
// Shared types and constants for the iterative divider: state encoding,
// div_op codes and small sign helpers.
package div_seq_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_ITER  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    // Bit 0 of div_op distinguishes unsigned (1) from signed (0).
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_seq_step.sv
// One restoring radix-2 division step: shift {rem, quo} left, trial-subtract
// the divisor and keep the difference when it is non-negative.
module div_step import div_seq_pkg::*; (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // The extra top bit makes the sign of the trial difference visible.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[XLEN]) begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shifted[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: stalls the pipeline via busy while
// iterating, then returns result and rd_addr_out with a one-cycle done pulse.
module div_seq import div_seq_pkg::*; (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic [4:0]      rd_addr_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_addr_out
);

    state_t          state;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [4:0]      rd_q;
    logic [5:0]      cnt;
    logic            q_neg;
    logic            r_neg;

    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] fast_result;
    logic            accept;
    logic            div_zero;
    logic            overflow;

    div_step u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (b_q),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    assign accept   = start && !flush && (state == S_IDLE || state == S_DONE);
    assign div_zero = (divisor == '0);
    assign overflow = is_signed_op(div_op) && (dividend == INT_MIN) && (divisor == '1);
    assign busy     = (state == S_PREP) || (state == S_ITER) || (state == S_FIXUP);

    // Divide-by-zero and signed overflow have fixed answers and skip iteration.
    always_comb begin
        fast_result = '0;
        if (div_zero)
            fast_result = div_op[1] ? dividend : '1;
        else
            fast_result = div_op[1] ? '0 : INT_MIN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            rd_q        <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            rd_addr_out <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (accept) begin
                            op_q <= div_op;
                            a_q  <= dividend;
                            b_q  <= divisor;
                            rd_q <= rd_addr_in;
                            if (div_zero || overflow) begin
                                result      <= fast_result;
                                rd_addr_out <= rd_addr_in;
                                done        <= 1'b1;
                                state       <= S_DONE;
                            end else begin
                                state <= S_PREP;
                            end
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_PREP: begin
                        quo_q <= abs_val(a_q, is_signed_op(op_q));
                        b_q   <= abs_val(b_q, is_signed_op(op_q));
                        rem_q <= '0;
                        cnt   <= '0;
                        q_neg <= is_signed_op(op_q) && (a_q[XLEN-1] ^ b_q[XLEN-1]);
                        r_neg <= is_signed_op(op_q) && a_q[XLEN-1];
                        state <= S_ITER;
                    end
                    S_ITER: begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                        cnt   <= cnt + 6'd1;
                        if (cnt == 6'd31)
                            state <= S_FIXUP;
                    end
                    S_FIXUP: begin
                        if (op_q[1])
                            result <= r_neg ? -rem_q : rem_q;
                        else
                            result <= q_neg ? -quo_q : quo_q;
                        rd_addr_out <= rd_q;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
